// File: rtl/mdu_sequencer_if.sv
// Handshake/data bundle between the E-stage pipeline and the multiply/divide sequencer.
interface mdu_sequencer_if;
    logic        req;
    logic        op_valid;
    logic [3:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_use_d;
    logic        busy;
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output req, op_valid, mdu_op, src_a, src_b, md_use_d,
        input  busy, stall, rdata, hi, lo
    );

    modport slave (
        input  req, op_valid, mdu_op, src_a, src_b, md_use_d,
        output busy, stall, rdata, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide controller for the E stage: computes the result at launch,
// holds it for a fixed latency, then commits it to HI/LO.
module mdu_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    mdu_sequencer_if.slave  bus
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;
    logic              pend_wr_q, pend_wr_d;

    logic              busy;
    logic              issue;
    logic              launch;
    logic              is_div;
    logic              div_zero;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [31:0]        divisor;

    assign busy     = (state_q == StRun);
    assign issue    = bus.op_valid & ~bus.req & ~busy;
    assign launch   = issue & (bus.mdu_op >= OpMult) & (bus.mdu_op <= OpDivu);
    assign is_div   = (bus.mdu_op == OpDiv) | (bus.mdu_op == OpDivu);
    assign div_zero = (bus.src_b == 32'd0);

    // Substitute a harmless divisor on divide-by-zero; that result is never committed.
    assign divisor = div_zero ? 32'd1 : bus.src_b;
    assign sa      = $signed(bus.src_a);
    assign sb      = $signed(divisor);
    assign sq      = sa / sb;
    assign sr      = sa % sb;

    assign prod_s = $signed({{32{bus.src_a[31]}}, bus.src_a})
                  * $signed({{32{bus.src_b[31]}}, bus.src_b});
    assign prod_u = {32'd0, bus.src_a} * {32'd0, bus.src_b};

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        unique case (bus.mdu_op)
            OpMult: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OpMultu: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OpDiv: begin
                // INT_MIN / -1 overflows the quotient; pin it to the architectural answer.
                if (bus.src_a == 32'h8000_0000 && bus.src_b == 32'hFFFF_FFFF) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = sr;
                    res_lo = sq;
                end
            end
            OpDivu: begin
                res_hi = bus.src_a % divisor;
                res_lo = bus.src_a / divisor;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    pend_wr_d = ~(is_div & div_zero);
                    cnt_d     = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                    state_d   = StRun;
                end else if (issue && bus.mdu_op == OpMthi) begin
                    hi_d = bus.src_a;
                end else if (issue && bus.mdu_op == OpMtlo) begin
                    lo_d = bus.src_a;
                end
            end
            StRun: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CntW'(1)) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign bus.busy  = busy;
    assign bus.stall = bus.md_use_d & (busy | launch);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.rdata = (bus.mdu_op == OpMfhi) ? hi_q :
                       (bus.mdu_op == OpMflo) ? lo_q : 32'd0;
endmodule
